// File: rtl/onehot_pkg.sv
// Shared constants and types for the pipelined one-hot encoder.
//   ONEHOT_N   : default one-hot vector width
//   ONEHOT_W   : default encoded index width
//   ERR_CNT_W  : default width of the saturating error counter
//   enc_result_t : encoder result at the default widths (code + error flag)
package onehot_pkg;

    localparam int ONEHOT_N  = 32;
    localparam int ONEHOT_W  = 5;
    localparam int ERR_CNT_W = 8;

    typedef struct packed {
        logic [ONEHOT_W-1:0] code;
        logic                err;
    } enc_result_t;

endpackage

// File: rtl/onehot_encode_core.sv
// Combinational one-hot to binary encoder.
//   vec_i  [N-1:0] : vector to encode
//   code_o [W-1:0] : index of the lowest set bit (0 when no bit is set)
//   err_o          : vector was zero-hot or multi-hot
module onehot_encode_core
    import onehot_pkg::*;
#(
    parameter int N = ONEHOT_N,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] code_o,
    output logic         err_o
);

    logic zero_hot;
    logic multi_hot;

    // Scanning from the top down lets the lowest set bit win.
    always_comb begin
        code_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                code_o = W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if more than one was set.
    assign zero_hot  = ~|vec_i;
    assign multi_hot = |(vec_i & (vec_i - {{(N-1){1'b0}}, 1'b1}));
    assign err_o     = zero_hot | multi_hot;

endmodule

// File: rtl/onehot_encode_pipe.sv
// Two-stage pipelined one-hot to binary encoder with valid/ready on both sides.
//   clk, reset_n        : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake, in_onehot [N-1:0] is the vector
//   out_valid/out_ready : downstream handshake, out_code [W-1:0] and out_err
//   clear_err           : synchronous clear of err_count
//   err_count [CNT_W-1:0] : saturating count of erroneous results delivered
module onehot_encode_pipe
    import onehot_pkg::*;
#(
    parameter int N     = ONEHOT_N,
    parameter int W     = $clog2(N),
    parameter int CNT_W = ERR_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_code,
    output logic             out_err,
    input  logic             clear_err,
    output logic [CNT_W-1:0] err_count
);

    logic [N-1:0]     s1_data_q;
    logic             s1_valid_q;
    logic [W-1:0]     s2_code_q;
    logic             s2_err_q;
    logic             s2_valid_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    logic [W-1:0]     enc_code;
    logic             enc_err;
    logic             s1_adv;
    logic             s2_adv;
    logic             out_fire;

    onehot_encode_core #(
        .N (N),
        .W (W)
    ) u_core (
        .vec_i  (s1_data_q),
        .code_o (enc_code),
        .err_o  (enc_err)
    );

    // Ready ripples back combinationally so a draining pipe accepts with no bubble.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign out_fire = s2_valid_q && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_data_q <= in_onehot;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_code_q  <= '0;
            s2_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_code_q <= enc_code;
                s2_err_q  <= enc_err;
            end
        end
    end

    // Clear takes priority over a coincident increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clear_err) begin
            err_cnt_d = '0;
        end else if (out_fire && s2_err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_code  = s2_code_q;
    assign out_err   = s2_err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_onehot_encode_pipe.sv
module tb_onehot_encode_pipe;
    import onehot_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_onehot;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_code;
    logic        out_err;
    logic        clear_err;
    logic [7:0]  err_count;

    int checks;
    int errors;
    int model_cnt;
    enc_result_t sb[$];

    onehot_encode_pipe #(
        .N     (32),
        .W     (5),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_onehot (in_onehot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_err   (out_err),
        .clear_err (clear_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic enc_result_t model_enc(input logic [31:0] v);
        enc_result_t r;
        logic found;
        r.code = '0;
        found  = 1'b0;
        for (int j = 0; j < 32; j++) begin
            if (v[j] && !found) begin
                r.code = 5'(j);
                found  = 1'b1;
            end
        end
        r.err = ($countones(v) != 1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, update scoreboard and
    // counter model, then check err_count after the edge. Returns at negedge.
    task automatic step();
        logic in_fire;
        logic out_fire;
        enc_result_t e;
        #1;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (out_fire) begin
            if (sb.size() == 0) begin
                chk("spurious_output", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_code", 32'(out_code), 32'(e.code));
                chk("out_err", 32'(out_err), 32'(e.err));
                if (!clear_err && e.err && model_cnt != 255) model_cnt++;
            end
        end
        if (clear_err) model_cnt = 0;
        if (in_fire) sb.push_back(model_enc(in_onehot));
        @(posedge clk);
        @(negedge clk);
        chk("err_count", 32'(err_count), 32'(model_cnt));
    endtask

    task automatic drain();
        int budget;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (sb.size() != 0 && budget < 50) begin
            step();
            budget++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        step();
        chk("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_cnt = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_onehot = '0;
        out_ready = 1'b0;
        clear_err = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_code", 32'(out_code), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Single vector, latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_onehot = 32'h0000_0001;
        step();
        in_valid = 1'b0;
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        step();
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_code", 32'(out_code), 32'd0);
        drain();

        // Back-to-back stream of every one-hot position
        for (int i = 0; i < 32; i++) begin
            in_valid  = 1'b1;
            in_onehot = 32'h1 << i;
            #1;
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            if (i >= 2) chk("stream_no_bubble", 32'(out_valid), 32'd1);
            step();
        end
        drain();

        // Zero-hot and multi-hot
        in_valid  = 1'b1;
        in_onehot = 32'h0;
        step();
        in_onehot = 32'h0000_0014;
        step();
        drain();
        chk("err_count_two", 32'(err_count), 32'd2);

        // Stall with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_onehot = 32'h8000_0000;
        step();
        in_onehot = 32'h0000_0100;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_code", 32'(out_code), 32'd31);
            step();
        end
        drain();

        // Saturation of the error counter
        in_valid  = 1'b1;
        in_onehot = 32'h0;
        repeat (260) step();
        drain();
        chk("err_count_sat", 32'(err_count), 32'd255);

        // Clear coincident with an erroneous transfer
        in_valid  = 1'b1;
        in_onehot = 32'h0;
        step();
        in_valid = 1'b0;
        step();
        chk("clr_out_valid", 32'(out_valid), 32'd1);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("clr_err_count", 32'(err_count), 32'd0);
        drain();

        // Reset mid-stream with both stages full
        in_valid  = 1'b1;
        in_onehot = 32'h0;
        step();
        in_valid = 1'b0;
        drain();
        chk("pre_rst_count", 32'(err_count), 32'd1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_onehot = 32'h0000_0004;
        step();
        in_onehot = 32'h0000_0003;
        step();
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_code", 32'(out_code), 32'd0);
        chk("async_err_count", 32'(err_count), 32'd0);
        sb.delete();
        model_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_onehot = 32'h0000_0040;
        step();
        in_valid = 1'b0;
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_code", 32'(out_code), 32'd6);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_encode_pipe.md
Name: onehot_encode_pipe

Overview:
- Pipelined one-hot to binary encoder. It performs the inverse of the processor's 1:2 / 5:32 decoder tree: an N-bit one-hot select (register-file write-enable vector, forwarding-match vector) becomes a W-bit index.
- Two register stages with a valid/ready handshake on both sides, so it can sit between pipeline stages.
- Flags inputs that are not one-hot and keeps a saturating count of them for debug.

Parameters:
- N, 32, width of the one-hot input vector (N >= 2).
- W, $clog2(N), width of the encoded output (5 at default).
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronised externally to clk.
- in_valid  input  1  upstream holds a vector on in_onehot.
- in_ready  output  1  block accepts in_onehot this cycle.
- in_onehot  input  N  one-hot select vector.
- out_valid  output  1  out_code and out_err are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- out_code  output  W  encoded index.
- out_err  output  1  the source vector was zero-hot or multi-hot.
- clear_err  input  1  synchronous clear of err_count.
- err_count  output  CNT_W  saturating count of erroneous results delivered.

Behaviour:
- Reset (reset_n=0, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, out_code=0, out_err=0, err_count=0. Stage data registers are cleared to 0.
- Reset mid-operation: all in-flight entries are discarded. No output is produced for them, and err_count is not updated.
- Handshake rules:
  - A transfer occurs on any edge where valid && ready.
  - in_valid/in_onehot must be held stable until accepted.
  - out_valid/out_code/out_err stay stable while out_valid && !out_ready.
- Stage 1 (S1) registers the raw vector: s1_data, s1_valid.
- Stage 2 (S2) registers the encoder result: out_code, out_err, out_valid.
- Advance and ready logic:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready, with no bubble.
- Latency: an input accepted at edge k appears with out_valid=1 after edge k+1, provided there is no stall. Full throughput is one vector per cycle.
- Stall: with out_ready=0 and both stages full, in_ready=0 and nothing moves. Data is never lost or duplicated.
- Encoding is performed on s1_data, between S1 and S2:
  - Exactly one bit i set: code=i, err=0.
  - Zero bits set: code=0, err=1.
  - Multiple bits set: code = lowest set index, err=1.
- err_count:
  - Increments by 1 on each output transfer (out_valid && out_ready) with out_err=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - clear_err=1 forces 0 on the next edge. If an increment occurs in the same cycle, clear wins and the result is 0.
- The encoder never produces X: all N input bits are fully decoded, and no index >= N is possible.

Decomposition:
- Package onehot_pkg:
  - localparams ONEHOT_N=32, ONEHOT_W=5, ERR_CNT_W=8.
  - typedef enc_result_t, a packed struct {logic [W-1:0] code; logic err;}.
- Sub-module onehot_encode_core: purely combinational. Maps N-bit vector to code, err using lowest-index priority plus a popcount>1 / zero detect. It is instantiated once between S1 and S2.
- onehot_encode_pipe holds the handshake, the two stage registers and the counter.

Test Plan:
- Reset then single input 32'h0000_0001, out_ready=1 -> two edges later out_valid=1, out_code=0, out_err=0, err_count=0.
- Back-to-back stream 32'h1<<i for i=0..31, out_ready=1 -> 32 consecutive outputs, code=i in order, in_ready never drops, no bubbles.
- Inputs 32'h0 then 32'h0000_0014 -> outputs (code=0, err=1) then (code=2, err=1); err_count=2.
- Fill the pipe with 32'h8000_0000 and 32'h0000_0100, then hold out_ready=0 for 5 cycles -> in_ready=0, out_code=31 held stable. Releasing out_ready gives 31 then 8, with no loss or duplicate.
- Deliver 260 zero vectors -> err_count saturates at 255. Then assert clear_err in the same cycle as an erroneous transfer -> err_count=0.
- Assert reset_n=0 mid-stream between edges with both stages full -> out_valid, out_code, err_count go to 0 immediately without a clock edge. After release, the first new input is the first output.
